mem_arb_ctrl: RTL and testbench

- Parametrised successor of the byte-serial memory access controller.
- Arbitrates between instruction fetch (IF) and the MEM stage for a single byte-wide RAM port.
- Serialises multi-byte loads, stores and fetches little-endian, tolerating a configurable RAM read latency.
- Returns per-requester done pulses with assembled data; supports fetch abort on pipeline flush.

---
 rtl/memctrl_pkg.sv | 37 +++
 rtl/mem_arb_ctrl_if.sv | 34 +++
 rtl/mem_byte_lane.sv | 77 +++++++
 rtl/mem_arb_ctrl.sv | 111 +++++++++++
 tb/tb_mem_arb_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/memctrl_pkg.sv
// Shared encodings for the byte-serial memory arbiter: FSM states, request
// opcodes, access sizes and RAM direction, plus the transfer-length helper.
package memctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_STORE = 3'd2;
    localparam state_t ST_FETCH = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_LOAD  = 2'b01;
    localparam logic [1:0] RW_STORE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_FULL = 2'd3;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    // Bytes moved for a MEM access, never more than the data path holds.
    function automatic int unsigned xfer_len(input logic [1:0] size, input int unsigned nb);
        int unsigned n;
        case (size)
            SZ_BYTE: n = 1;
            SZ_HALF: n = 2;
            SZ_WORD: n = 4;
            default: n = nb;
        endcase
        return (n > nb) ? nb : n;
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Request/response and RAM-side signals of the memory arbiter, bundled so the
// controller takes one port; slave is the controller, master its environment.
interface mem_arb_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_inst;

    logic [1:0]        mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic [7:0]        ram_din;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;

    modport slave (
        input  if_req, if_addr, if_flush, mem_rw, mem_addr, mem_wdata, mem_size, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_rw, ram_addr, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush, mem_rw, mem_addr, mem_wdata, mem_size, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_rw, ram_addr, ram_dout
    );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte serialiser: issues one RAM byte per cycle, shifts out store data and
// assembles read bytes into their lanes RAM_RD_LAT cycles after issue.
module mem_byte_lane #(
    parameter int DATA_W     = 32,
    parameter int RAM_RD_LAT = 1,
    localparam int NB        = DATA_W / 8,
    localparam int CW        = $clog2(NB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              is_write_i,
    input  logic [CW-1:0]     n_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        ram_din_i,
    output logic              issue_o,
    output logic [CW-1:0]     issue_idx_o,
    output logic              last_o,
    output logic [7:0]        dout_o,
    output logic [DATA_W-1:0] data_o
);
    logic                  active_q;
    logic                  wr_q;
    logic [CW-1:0]         n_q, iss_q, rcv_q;
    logic [RAM_RD_LAT-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]     dat_q;
    logic                  rx_vld;

    assign issue_o     = active_q && (iss_q < n_q);
    assign issue_idx_o = iss_q;
    assign rx_vld      = active_q && !wr_q && pend_q[RAM_RD_LAT-1];
    assign last_o      = wr_q ? (issue_o && iss_q == n_q - 1'b1)
                              : (rx_vld && rcv_q == n_q - 1'b1);
    assign dout_o      = dat_q[7:0];
    assign data_o      = dat_q;

    // pend_q tracks in-flight reads; its top bit marks the byte arriving now.
    always_comb begin
        pend_d    = pend_q << 1;
        pend_d[0] = issue_o && !wr_q;
    end

    // NOTE: dat_q is pure datapath, overwritten at every start and only
    // observed after a completed transfer, so it carries no reset.
    always_ff @(posedge clk) begin
        if (start_i) begin
            dat_q <= is_write_i ? wdata_i : '0;
        end else if (active_q) begin
            if (wr_q && issue_o) dat_q <= dat_q >> 8;
            if (rx_vld)          dat_q[{rcv_q, 3'b000} +: 8] <= ram_din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            active_q <= 1'b0;
            wr_q     <= 1'b0;
            n_q      <= '0;
            iss_q    <= '0;
            rcv_q    <= '0;
            pend_q   <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            wr_q     <= is_write_i;
            n_q      <= n_i;
            iss_q    <= '0;
            rcv_q    <= '0;
            pend_q   <= '0;
        end else if (active_q) begin
            pend_q <= pend_d;
            if (issue_o) iss_q <= iss_q + 1'b1;
            if (rx_vld)  rcv_q <= rcv_q + 1'b1;
            if (last_o)  active_q <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbiter and FSM sharing one byte-wide RAM port between instruction fetch
// and the MEM stage (MEM first), with fetch abort on flush.
module mem_arb_ctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arb_ctrl_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(NB + 1);

    state_t            state_q, state_d, own_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] if_inst_q, mem_rdata_q;

    logic              lane_start, lane_clear, lane_wr;
    logic [CW-1:0]     lane_n, lane_idx;
    logic              lane_issue, lane_last;
    logic [7:0]        lane_dout;
    logic [DATA_W-1:0] lane_data;
    logic              ram_wr, if_fin, mem_fin, load_fin;

    mem_byte_lane #(
        .DATA_W     (DATA_W),
        .RAM_RD_LAT (RAM_RD_LAT)
    ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .start_i     (lane_start),
        .clear_i     (lane_clear),
        .is_write_i  (lane_wr),
        .n_i         (lane_n),
        .wdata_i     (bus.mem_wdata),
        .ram_din_i   (bus.ram_din),
        .issue_o     (lane_issue),
        .issue_idx_o (lane_idx),
        .last_o      (lane_last),
        .dout_o      (lane_dout),
        .data_o      (lane_data)
    );

    // NOTE: every signal gets its default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        lane_start = 1'b0;
        lane_clear = 1'b0;
        lane_wr    = 1'b0;
        lane_n     = CW'(NB);
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rw == RW_LOAD || bus.mem_rw == RW_STORE) begin
                    state_d    = (bus.mem_rw == RW_LOAD) ? ST_LOAD : ST_STORE;
                    lane_start = 1'b1;
                    lane_wr    = (bus.mem_rw == RW_STORE);
                    lane_n     = CW'(xfer_len(bus.mem_size, NB));
                end else if (bus.if_req && !bus.if_flush) begin
                    state_d    = ST_FETCH;
                    lane_start = 1'b1;
                end
            end
            ST_LOAD, ST_STORE: if (lane_last) state_d = ST_DONE;
            ST_FETCH: begin
                if (bus.if_flush) begin
                    state_d    = ST_IDLE;
                    lane_clear = 1'b1;
                end else if (lane_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A flush in the fetch DONE cycle drops the pulse and keeps the old word.
    assign if_fin   = (state_q == ST_DONE) && (own_q == ST_FETCH) && !bus.if_flush;
    assign mem_fin  = (state_q == ST_DONE) && (own_q != ST_FETCH);
    assign load_fin = mem_fin && (own_q == ST_LOAD);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            own_q       <= ST_IDLE;
            addr_q      <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (lane_start) begin
                own_q  <= state_d;
                addr_q <= (state_d == ST_FETCH) ? bus.if_addr : bus.mem_addr;
            end
            if (if_fin)   if_inst_q   <= lane_data;
            if (load_fin) mem_rdata_q <= lane_data;
        end
    end

    assign ram_wr        = lane_issue && (own_q == ST_STORE);
    assign bus.ram_rw    = ram_wr ? RAM_WRITE : RAM_READ;
    assign bus.ram_addr  = lane_issue ? addr_q + ADDR_W'(lane_idx) : '0;
    assign bus.ram_dout  = ram_wr ? lane_dout : 8'h00;
    assign bus.if_done   = if_fin;
    assign bus.if_inst   = if_fin ? lane_data : if_inst_q;
    assign bus.mem_done  = mem_fin;
    assign bus.mem_rdata = load_fin ? lane_data : mem_rdata_q;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: one instance with RAM_RD_LAT=1 and one with
// RAM_RD_LAT=3, each attached to a small byte RAM model.
module tb_mem_arb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arb_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_arb_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_RD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_RD_LAT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [7:0] mem1 [1024];
    logic [7:0] mem3 [1024];
    logic [7:0] pipe1 [1];
    logic [7:0] pipe3 [3];

    assign bus1.ram_din = pipe1[0];
    assign bus3.ram_din = pipe3[2];

    always @(posedge clk) begin
        pipe1[0] <= mem1[bus1.ram_addr[9:0]];
        pipe3[2] <= pipe3[1];
        pipe3[1] <= pipe3[0];
        pipe3[0] <= mem3[bus3.ram_addr[9:0]];
    end

    always @(posedge clk) begin
        if (bus1.ram_rw == 1'b0) mem1[bus1.ram_addr[9:0]] = bus1.ram_dout;
        if (bus3.ram_rw == 1'b0) mem3[bus3.ram_addr[9:0]] = bus3.ram_dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[10'h100] = 8'h11; mem1[10'h101] = 8'h22;
        mem1[10'h102] = 8'h33; mem1[10'h103] = 8'h44;
        mem1[10'h000] = 8'h13; mem1[10'h001] = 8'h05;
        mem1[10'h002] = 8'h10; mem1[10'h003] = 8'h00;
        mem1[10'h008] = 8'hF0;
        mem1[10'h022] = 8'h5A; mem1[10'h023] = 8'h77;
        mem3[10'h040] = 8'hA1; mem3[10'h041] = 8'hB2;
        mem3[10'h042] = 8'hC3; mem3[10'h043] = 8'hD4;

        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.if_flush = 1'b0;
        bus1.mem_rw = 2'b00; bus1.mem_addr = '0; bus1.mem_wdata = '0; bus1.mem_size = 2'd0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.if_flush = 1'b0;
        bus3.mem_rw = 2'b00; bus3.mem_addr = '0; bus3.mem_wdata = '0; bus3.mem_size = 2'd0;

        // Reset state
        rst = 1'b1;
        next(); next();
        check("rst ram_rw",    64'(bus1.ram_rw),    64'h1);
        check("rst ram_addr",  64'(bus1.ram_addr),  64'h0);
        check("rst ram_dout",  64'(bus1.ram_dout),  64'h0);
        check("rst if_done",   64'(bus1.if_done),   64'h0);
        check("rst mem_done",  64'(bus1.mem_done),  64'h0);
        check("rst if_inst",   64'(bus1.if_inst),   64'h0);
        check("rst mem_rdata", 64'(bus1.mem_rdata), 64'h0);
        rst = 1'b0;
        next();

        // Word load from 0x100, latency 1
        bus1.mem_rw = 2'b01; bus1.mem_addr = 32'h100; bus1.mem_size = 2'd2;
        next();
        check("ld c0 ram_rw",   64'(bus1.ram_rw),   64'h1);
        check("ld c0 ram_addr", 64'(bus1.ram_addr), 64'h100);
        for (int i = 1; i < 4; i++) begin
            next();
            check("ld ram_addr", 64'(bus1.ram_addr), 64'h100 + 64'(i));
        end
        next();
        check("ld c4 drain addr", 64'(bus1.ram_addr), 64'h0);
        check("ld c4 mem_done",   64'(bus1.mem_done), 64'h0);
        next();
        check("ld c5 mem_done",  64'(bus1.mem_done),  64'h1);
        check("ld c5 mem_rdata", 64'(bus1.mem_rdata), 64'h44332211);
        check("ld c5 if_done",   64'(bus1.if_done),   64'h0);
        bus1.mem_rw = 2'b00;
        next();
        check("ld after done",  64'(bus1.mem_done),  64'h0);
        check("ld rdata hold",  64'(bus1.mem_rdata), 64'h44332211);

        // Half store of 0xAABBCCDD to 0x20
        bus1.mem_rw = 2'b10; bus1.mem_addr = 32'h20; bus1.mem_size = 2'd1;
        bus1.mem_wdata = 32'hAABBCCDD;
        next();
        check("st c0 ram_rw",   64'(bus1.ram_rw),   64'h0);
        check("st c0 ram_addr", 64'(bus1.ram_addr), 64'h20);
        check("st c0 ram_dout", 64'(bus1.ram_dout), 64'hDD);
        next();
        check("st c1 ram_rw",   64'(bus1.ram_rw),   64'h0);
        check("st c1 ram_addr", 64'(bus1.ram_addr), 64'h21);
        check("st c1 ram_dout", 64'(bus1.ram_dout), 64'hCC);
        next();
        check("st c2 mem_done", 64'(bus1.mem_done), 64'h1);
        check("st c2 ram_rw",   64'(bus1.ram_rw),   64'h1);
        bus1.mem_rw = 2'b00;
        next();
        check("st mem 0x20", 64'(mem1[10'h020]), 64'hDD);
        check("st mem 0x21", 64'(mem1[10'h021]), 64'hCC);
        check("st mem 0x22", 64'(mem1[10'h022]), 64'h5A);

        // Simultaneous fetch at 0x0 and byte load at 0x8: load wins
        bus1.if_req = 1'b1; bus1.if_addr = 32'h0;
        bus1.mem_rw = 2'b01; bus1.mem_addr = 32'h8; bus1.mem_size = 2'd0;
        next();
        check("arb c0 ram_addr", 64'(bus1.ram_addr), 64'h8);
        next();
        check("arb c1 drain", 64'(bus1.ram_addr), 64'h0);
        next();
        check("arb ld mem_done",  64'(bus1.mem_done),  64'h1);
        check("arb ld mem_rdata", 64'(bus1.mem_rdata), 64'hF0);
        check("arb ld if_done",   64'(bus1.if_done),   64'h0);
        bus1.mem_rw = 2'b00;
        next();
        check("arb idle if_done", 64'(bus1.if_done), 64'h0);
        next();
        check("arb fetch c0 rw", 64'(bus1.ram_rw), 64'h1);
        for (int i = 0; i < 4; i++) next();
        check("arb fetch c4 if_done", 64'(bus1.if_done), 64'h0);
        next();
        check("arb fetch if_done",  64'(bus1.if_done),  64'h1);
        check("arb fetch if_inst",  64'(bus1.if_inst),  64'h00100513);
        check("arb fetch mem_done", 64'(bus1.mem_done), 64'h0);
        bus1.if_req = 1'b0;
        next();

        // Flush in cycle 2 of a fetch, then a new fetch
        bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
        next();
        check("fl c0 ram_addr", 64'(bus1.ram_addr), 64'h100);
        next();
        next();
        bus1.if_flush = 1'b1;
        check("fl c2 ram_addr", 64'(bus1.ram_addr), 64'h102);
        check("fl c2 if_done",  64'(bus1.if_done),  64'h0);
        next();
        check("fl idle ram_rw",   64'(bus1.ram_rw),   64'h1);
        check("fl idle ram_addr", 64'(bus1.ram_addr), 64'h0);
        check("fl idle if_done",  64'(bus1.if_done),  64'h0);
        bus1.if_flush = 1'b0; bus1.if_addr = 32'h20;
        next();
        check("fl refetch addr", 64'(bus1.ram_addr), 64'h20);
        check("fl inst kept",    64'(bus1.if_inst),  64'h00100513);
        for (int i = 0; i < 4; i++) next();
        next();
        check("fl refetch if_done", 64'(bus1.if_done), 64'h1);
        check("fl refetch if_inst", 64'(bus1.if_inst), 64'h775ACCDD);
        bus1.if_req = 1'b0;
        next();

        // Word fetch with RAM_RD_LAT=3
        bus3.if_req = 1'b1; bus3.if_addr = 32'h40;
        next();
        check("lat3 c0 ram_addr", 64'(bus3.ram_addr), 64'h40);
        for (int i = 0; i < 6; i++) next();
        check("lat3 c6 if_done", 64'(bus3.if_done), 64'h0);
        next();
        check("lat3 c7 if_done", 64'(bus3.if_done), 64'h1);
        check("lat3 c7 if_inst", 64'(bus3.if_inst), 64'hD4C3B2A1);
        bus3.if_req = 1'b0;
        next();

        // Reset in the middle of a word store
        bus1.mem_rw = 2'b10; bus1.mem_addr = 32'h30; bus1.mem_size = 2'd2;
        bus1.mem_wdata = 32'h11223344;
        next();
        check("rs c0 ram_rw",   64'(bus1.ram_rw),   64'h0);
        check("rs c0 ram_dout", 64'(bus1.ram_dout), 64'h44);
        rst = 1'b1; bus1.mem_rw = 2'b00;
        next();
        check("rs ram_rw",    64'(bus1.ram_rw),    64'h1);
        check("rs ram_addr",  64'(bus1.ram_addr),  64'h0);
        check("rs ram_dout",  64'(bus1.ram_dout),  64'h0);
        check("rs mem_done",  64'(bus1.mem_done),  64'h0);
        check("rs mem_rdata", 64'(bus1.mem_rdata), 64'h0);
        check("rs if_inst",   64'(bus1.if_inst),   64'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            check("rs no mem_done", 64'(bus1.mem_done), 64'h0);
        end
        check("rs mem 0x30", 64'(mem1[10'h030]), 64'h44);
        check("rs mem 0x31", 64'(mem1[10'h031]), 64'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
